// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the memory stage and its M/W register.
//   XLEN        - datapath width
//   REG_ADDR_W  - register-file address width
//   ST_IDLE/ST_BUSY - memory-stage FSM state encoding
//   word_aligned()  - true when the low two address bits are zero
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic word_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/mw_pipe_reg.sv
// mw_pipe_reg: M/W pipeline register. Every falling edge it captures either
// the op fields presented on its inputs (load_op=1) or a bubble (all zero).
// Synchronous active-low reset, sampled on the falling edge.
// Ports:
//   clk, rst                 - clock (falling edge) and active-low sync reset
//   load_op                  - 1 = capture op fields, 0 = capture bubble
//   *_in                     - op fields from the memory stage
//   RegWriteW .. RdW         - registered writeback-stage fields
module mw_pipe_reg
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_op,
    input  logic                  reg_write_in,
    input  logic                  result_src_in,
    input  logic [XLEN-1:0]       read_data_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       pc_plus4_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic [XLEN-1:0]       ALUResultW,
    output logic [XLEN-1:0]       PCPlus4W,
    output logic [REG_ADDR_W-1:0] RdW
);

    logic                  reg_write_q,  reg_write_d;
    logic                  result_src_q, result_src_d;
    logic [XLEN-1:0]       read_data_q,  read_data_d;
    logic [XLEN-1:0]       alu_result_q, alu_result_d;
    logic [XLEN-1:0]       pc_plus4_q,   pc_plus4_d;
    logic [REG_ADDR_W-1:0] rd_q,         rd_d;

    always_comb begin
        reg_write_d  = 1'b0;
        result_src_d = 1'b0;
        read_data_d  = '0;
        alu_result_d = '0;
        pc_plus4_d   = '0;
        rd_d         = '0;
        if (load_op) begin
            reg_write_d  = reg_write_in;
            result_src_d = result_src_in;
            read_data_d  = read_data_in;
            alu_result_d = alu_result_in;
            pc_plus4_d   = pc_plus4_in;
            rd_d         = rd_in;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
    assign ReadDataW  = read_data_q;
    assign ALUResultW = alu_result_q;
    assign PCPlus4W   = pc_plus4_q;
    assign RdW        = rd_q;

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: M stage of the 5-stage RISC-V pipeline. Issues word
// loads/stores on a req/ack data-memory port, stalls upstream while an
// access is outstanding, and feeds the M/W register (mw_pipe_reg).
// All state updates on the falling edge of clk; rst is synchronous active-low.
// Optional build macro MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES
// BUSY cycles without dmem_ack and pulse bus_err (tied 0 otherwise).
// Ports:
//   M-stage inputs : RegWriteM, ResultSrcM, MemWriteM, ALUResultM,
//                    WriteDataM, RdM, PCPlus4M
//   stall_M        : combinational hold for fetch/decode/execute
//   dmem_*         : registered request fields, dmem_ack/dmem_rdata inputs
//   W outputs      : RegWriteW, ResultSrcW, ReadDataW, ALUResultW, PCPlus4W, RdW
//   misalign_err   : registered pulse, misaligned access dropped
//   bus_err        : pulse during the cycle a timeout abort is taken
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access outstanding; ALU ops flow through, memops issue
// BUSY    | request on the bus; W holds a bubble until ack (or timeout)
module memory_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [XLEN-1:0]       WriteDataM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [XLEN-1:0]       PCPlus4M,
    output logic                  stall_M,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic [XLEN-1:0]       ALUResultW,
    output logic [XLEN-1:0]       PCPlus4W,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  misalign_err,
    output logic                  bus_err
);

    logic [0:0]      state_q, state_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic            misalign_err_q, misalign_err_d;

    logic            memop;
    logic            aligned;
    logic            timeout_hit;
    logic            w_load;
    logic [XLEN-1:0] w_read_data;

    assign memop   = ResultSrcM | MemWriteM;
    assign aligned = word_aligned(ALUResultM[1:0]);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 5) ? $clog2(TIMEOUT_CYCLES) : 5;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero while IDLE, so it is already clear on BUSY entry.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (!dmem_ack) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // An ack in the same cycle takes priority over the abort.
    assign timeout_hit = (state_q == ST_BUSY) && !dmem_ack &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err     = timeout_hit & rst;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        misalign_err_d = 1'b0;
        w_load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!memop) begin
                    w_load = 1'b1;
                end else if (!aligned) begin
                    misalign_err_d = 1'b1;
                end else begin
                    state_d      = ST_BUSY;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = MemWriteM;
                    dmem_addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
                    dmem_wdata_d = WriteDataM;
                end
            end
            ST_BUSY: begin
                // M inputs are still the accepted op because stall_M held them.
                if (dmem_ack) begin
                    w_load     = 1'b1;
                    dmem_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (timeout_hit) begin
                    dmem_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign stall_M = ((state_q == ST_IDLE) && memop && aligned) ||
                     ((state_q == ST_BUSY) && !dmem_ack && !timeout_hit);

    // Memory data reaches W only for a completing load; ALU ops and stores get 0.
    assign w_read_data = ((state_q == ST_BUSY) && ResultSrcM) ? dmem_rdata : '0;

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign misalign_err = misalign_err_q;

    mw_pipe_reg u_mw_pipe_reg (
        .clk           (clk),
        .rst           (rst),
        .load_op       (w_load),
        .reg_write_in  (RegWriteM),
        .result_src_in (ResultSrcM),
        .read_data_in  (w_read_data),
        .alu_result_in (ALUResultM),
        .pc_plus4_in   (PCPlus4M),
        .rd_in         (RdM),
        .RegWriteW     (RegWriteW),
        .ResultSrcW    (ResultSrcW),
        .ReadDataW     (ReadDataW),
        .ALUResultW    (ALUResultW),
        .PCPlus4W      (PCPlus4W),
        .RdW           (RdW)
    );

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios plus randomized op
// streams, checked against a transaction-level model of each operation.
module tb_memory_access_stage;

    logic        clk = 1'b1;
    logic        rst;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        stall_M, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        RegWriteW, ResultSrcW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;
    logic        misalign_err, bus_err;

    memory_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .stall_M(stall_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic        rw, rs, mw;
        logic [31:0] alu, wd, pc;
        logic [4:0]  rd;
    } op_t;

    task automatic drive(input op_t o);
        RegWriteM  = o.rw;
        ResultSrcM = o.rs;
        MemWriteM  = o.mw;
        ALUResultM = o.alu;
        WriteDataM = o.wd;
        PCPlus4M   = o.pc;
        RdM        = o.rd;
    endtask

    task automatic drive_nop();
        op_t z;
        z = '{rw: 1'b0, rs: 1'b0, mw: 1'b0, alu: 32'h0, wd: 32'h0, pc: 32'h0, rd: 5'h0};
        drive(z);
    endtask

    task automatic check_w(input string tag, input logic rw, input logic rs,
                           input logic [31:0] rdata, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [4:0] rd);
        chk({tag, ".RegWriteW"},  RegWriteW,  rw);
        chk({tag, ".ResultSrcW"}, ResultSrcW, rs);
        chk({tag, ".ReadDataW"},  ReadDataW,  rdata);
        chk({tag, ".ALUResultW"}, ALUResultW, alu);
        chk({tag, ".PCPlus4W"},   PCPlus4W,   pc);
        chk({tag, ".RdW"},        RdW,        rd);
    endtask

    task automatic check_bubble(input string tag);
        check_w(tag, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'h0);
    endtask

    // Called just after a falling edge with the stage idle. Presents the op,
    // plays the memory side (ack after 'waits' BUSY cycles, data 'rdata'),
    // and returns just after the edge that finishes it.
    task automatic run_op(input string tag, input op_t o, input int waits,
                          input logic idle_ack, input logic [31:0] rdata);
        logic memop, aligned;
        memop   = o.rs | o.mw;
        aligned = (o.alu % 4) == 0;
        drive(o);
        dmem_ack   = idle_ack;
        dmem_rdata = $urandom;
        #1;
        chk({tag, ".stall_accept"}, stall_M, memop && aligned);
        chk({tag, ".bus_err_idle"}, bus_err, 1'b0);
        @(negedge clk); #1;
        dmem_ack = 1'b0;
        if (!memop) begin
            check_w({tag, ".alu"}, o.rw, o.rs, 32'h0, o.alu, o.pc, o.rd);
            chk({tag, ".req_alu"}, dmem_req, 1'b0);
            chk({tag, ".misalign_alu"}, misalign_err, 1'b0);
            return;
        end
        if (!aligned) begin
            check_bubble({tag, ".misal"});
            chk({tag, ".req_misal"}, dmem_req, 1'b0);
            chk({tag, ".misalign_pulse"}, misalign_err, 1'b1);
            return;
        end
        for (int i = 0; i <= waits; i++) begin
            chk({tag, ".req"}, dmem_req, 1'b1);
            chk({tag, ".we"}, dmem_we, o.mw);
            chk({tag, ".addr"}, dmem_addr, o.alu);
            chk({tag, ".wdata"}, dmem_wdata, o.wd);
            chk({tag, ".misalign_busy"}, misalign_err, 1'b0);
            check_bubble({tag, ".busy"});
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? rdata : $urandom;
            #1;
            chk({tag, ".stall_busy"}, stall_M, i < waits);
            chk({tag, ".bus_err_busy"}, bus_err, 1'b0);
            @(negedge clk); #1;
        end
        dmem_ack = 1'b0;
        check_w({tag, ".done"}, o.rw, o.rs, o.rs ? rdata : 32'h0, o.alu, o.pc, o.rd);
        chk({tag, ".req_done"}, dmem_req, 1'b0);
    endtask

    op_t o;

    initial begin
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive_nop();
        repeat (2) @(negedge clk);
        #1;
        check_bubble("reset");
        chk("reset.req", dmem_req, 1'b0);
        chk("reset.addr", dmem_addr, 32'h0);
        chk("reset.misalign", misalign_err, 1'b0);
        chk("reset.stall", stall_M, 1'b0);
        rst = 1'b1;

        // Directed scenarios.
        o = '{rw: 1'b1, rs: 1'b0, mw: 1'b0, alu: 32'h1234, wd: 32'h0, pc: 32'h44, rd: 5'd5};
        run_op("alu_dir", o, 0, 1'b0, 32'h0);
        o = '{rw: 1'b1, rs: 1'b1, mw: 1'b0, alu: 32'h100, wd: 32'h0, pc: 32'h48, rd: 5'd7};
        run_op("load_dir", o, 0, 1'b0, 32'hDEADBEEF);
        o = '{rw: 1'b0, rs: 1'b0, mw: 1'b1, alu: 32'h200, wd: 32'hCAFEF00D, pc: 32'h4C, rd: 5'd0};
        run_op("store_dir", o, 3, 1'b0, 32'h0);
        o = '{rw: 1'b1, rs: 1'b1, mw: 1'b0, alu: 32'h102, wd: 32'h0, pc: 32'h50, rd: 5'd9};
        run_op("misal_dir", o, 0, 1'b0, 32'h0);
        drive_nop();
        #1;
        chk("misal_dir.stall_after", stall_M, 1'b0);
        @(negedge clk); #1;
        chk("misal_dir.single_pulse", misalign_err, 1'b0);

        // Reset while BUSY, then a late ack must be ignored.
        o = '{rw: 1'b1, rs: 1'b1, mw: 1'b0, alu: 32'h300, wd: 32'h55, pc: 32'h60, rd: 5'd3};
        drive(o);
        @(negedge clk); #1;
        chk("rstbusy.req_before", dmem_req, 1'b1);
        rst = 1'b0;
        @(negedge clk); #1;
        drive_nop();
        chk("rstbusy.req", dmem_req, 1'b0);
        chk("rstbusy.we", dmem_we, 1'b0);
        chk("rstbusy.addr", dmem_addr, 32'h0);
        chk("rstbusy.wdata", dmem_wdata, 32'h0);
        check_bubble("rstbusy");
        rst = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBADC0DE5;
        #1;
        chk("rstbusy.stall_late_ack", stall_M, 1'b0);
        @(negedge clk); #1;
        dmem_ack = 1'b0;
        chk("rstbusy.req_late_ack", dmem_req, 1'b0);
        check_bubble("rstbusy.late_ack");

        // Randomized op stream, including back-to-back memops.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            o.rw  = 1'($urandom);
            o.wd  = $urandom;
            o.pc  = $urandom;
            o.rd  = 5'($urandom);
            o.alu = $urandom;
            o.rs  = (kind == 1) || (kind == 3 && o.alu[31]);
            o.mw  = (kind == 2) || (kind == 3 && !o.alu[31]);
            if (kind == 0) begin
                o.rs = 1'b0;
                o.mw = 1'b0;
            end else if (kind == 3) begin
                if (o.alu[1:0] == 2'b00) o.alu[0] = 1'b1;
            end else begin
                o.alu[1:0] = 2'b00;
            end
            run_op("rand", o, $urandom_range(0, 3), 1'($urandom), $urandom);
        end

`ifdef MEM_TIMEOUT_EN
        o = '{rw: 1'b0, rs: 1'b0, mw: 1'b1, alu: 32'h400, wd: 32'h1, pc: 32'h70, rd: 5'd1};
        drive(o);
        dmem_ack = 1'b0;
        @(negedge clk); #1;
        drive_nop();
        for (int i = 0; i < 16; i++) begin
            chk("tmo.req", dmem_req, 1'b1);
            #1;
            chk("tmo.stall", stall_M, i < 15);
            chk("tmo.bus_err", bus_err, i == 15);
            @(negedge clk); #1;
        end
        chk("tmo.req_drop", dmem_req, 1'b0);
        chk("tmo.bus_err_after", bus_err, 1'b0);
        check_bubble("tmo");
`endif

        drive_nop();
        @(negedge clk); #1;
        chk("end.req", dmem_req, 1'b0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
